// File: rtl/ro_scan_counter.sv
// Ring-oscillator scan: steps the 16:1 mux through enabled channels, counts RO edges per window,
// results leave over VALID/READY (scan stalls in HOLD until taken). Build with RO_CNT_SAT_EN for saturating counters.
module ro_scan_counter #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [15:0]      i_ch_mask,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_ro_out,
    output logic [3:0]       o_s,
    output logic             o_en_ro,
    output logic             o_busy,
    output logic             o_data_valid,
    input  logic             i_data_ready,
    output logic [3:0]       o_data_ch,
    output logic [CNT_W-1:0] o_data_cnt,
    output logic             o_data_ovf,
    output logic             o_done
);

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_HOLD,
        ST_FINISH
    } state_t;

    state_t            r_state;
    logic [15:0]       r_mask;
    logic [WIN_W-1:0]  r_win;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [ST_W-1:0]   r_settle_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_sync1, r_sync2, r_sync3;
    logic [3:0]        r_s;
    logic              r_en_ro;
    logic              r_busy;
    logic              r_data_valid;
    logic [3:0]        r_data_ch;
    logic [CNT_W-1:0]  r_data_cnt;
    logic              r_data_ovf;
    logic              r_done;

    logic              w_edge;
    logic              w_first_vld;
    logic [3:0]        w_first_idx;
    logic              w_next_vld;
    logic [3:0]        w_next_idx;
    logic [WIN_W-1:0]  w_win_last;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ovf_nxt;

    assign w_edge     = r_sync2 & ~r_sync3;
    assign w_win_last = (r_win == '0) ? '0 : r_win - WIN_W'(1);

    // Descending loops so the lowest qualifying index wins.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = 4'd0;
        w_next_vld  = 1'b0;
        w_next_idx  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = 4'(i);
            end
            if (r_mask[i] && (i > int'(r_s))) begin
                w_next_vld = 1'b1;
                w_next_idx = 4'(i);
            end
        end
    end

`ifdef RO_CNT_SAT_EN
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_edge) begin
            if (&r_cnt) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W:0] w_sum;
    assign w_sum     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_edge};
    assign w_cnt_nxt = w_sum[CNT_W-1:0];
    assign w_ovf_nxt = r_ovf | w_sum[CNT_W];
`endif

    // RO_OUT is asynchronous; two flops resolve metastability, the third gives the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_ro_out;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_win        <= '0;
            r_win_cnt    <= '0;
            r_settle_cnt <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_s          <= 4'd0;
            r_en_ro      <= 1'b0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_ch    <= 4'd0;
            r_data_cnt   <= '0;
            r_data_ovf   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mask <= i_ch_mask;
                        r_win  <= i_win_len;
                        r_busy <= 1'b1;
                        if (w_first_vld) begin
                            r_s          <= w_first_idx;
                            r_en_ro      <= 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_SETTLE: begin
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                    r_win_cnt <= '0;
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_COUNT;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + ST_W'(1);
                    end
                end
                ST_COUNT: begin
                    r_cnt     <= w_cnt_nxt;
                    r_ovf     <= w_ovf_nxt;
                    r_win_cnt <= r_win_cnt + WIN_W'(1);
                    if (r_win_cnt == w_win_last) begin
                        r_state      <= ST_HOLD;
                        r_en_ro      <= 1'b0;
                        r_data_valid <= 1'b1;
                        r_data_ch    <= r_s;
                        r_data_cnt   <= w_cnt_nxt;
                        r_data_ovf   <= w_ovf_nxt;
                    end
                end
                ST_HOLD: begin
                    if (i_data_ready) begin
                        r_data_valid <= 1'b0;
                        if (w_next_vld) begin
                            r_s          <= w_next_idx;
                            r_en_ro      <= 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_s     <= 4'd0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_s          = r_s;
    assign o_en_ro      = r_en_ro;
    assign o_busy       = r_busy;
    assign o_data_valid = r_data_valid;
    assign o_data_ch    = r_data_ch;
    assign o_data_cnt   = r_data_cnt;
    assign o_data_ovf   = r_data_ovf;
    assign o_done       = r_done;

endmodule

// File: tb/tb_ro_scan_counter.sv
// Directed bench for ro_scan_counter: a 16-bit instance and a 4-bit-counter instance share all stimulus.
module tb_ro_scan_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] ch_mask;
    logic [15:0] win_len;
    logic        ro;
    logic        ready;

    logic [3:0]  s, data_ch;
    logic        en_ro, busy, data_valid, data_ovf, done;
    logic [15:0] data_cnt;

    logic [3:0]  s4, data_ch4;
    logic        en_ro4, busy4, data_valid4, data_ovf4, done4;
    logic [3:0]  data_cnt4;

    int n_chk;
    int n_err;

    ro_scan_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ch_mask(ch_mask),
        .i_win_len(win_len), .i_ro_out(ro), .o_s(s), .o_en_ro(en_ro), .o_busy(busy),
        .o_data_valid(data_valid), .i_data_ready(ready), .o_data_ch(data_ch),
        .o_data_cnt(data_cnt), .o_data_ovf(data_ovf), .o_done(done)
    );

    ro_scan_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ch_mask(ch_mask),
        .i_win_len(win_len), .i_ro_out(ro), .o_s(s4), .o_en_ro(en_ro4), .o_busy(busy4),
        .o_data_valid(data_valid4), .i_data_ready(ready), .o_data_ch(data_ch4),
        .o_data_cnt(data_cnt4), .o_data_ovf(data_ovf4), .o_done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RO source: free-running period-4 square wave, or a requested number of single-edge pulses.
    logic ro_free;
    int   ro_req;
    int   ro_done;
    int   ro_ph;
    initial begin
        ro = 1'b0;
        ro_done = 0;
        ro_ph = 0;
    end
    always @(negedge clk) begin
        if (ro_free || (ro_done < ro_req)) begin
            ro = (ro_ph < 2);
            if (ro_ph == 3) begin
                ro_ph = 0;
                if (!ro_free) ro_done++;
            end else begin
                ro_ph++;
            end
        end else begin
            ro = 1'b0;
            ro_ph = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] m, input logic [15:0] w);
        tick();
        ch_mask = m;
        win_len = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_mask = 16'hFFFF;
        win_len = 16'hFFFF;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!data_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'd0, data_valid}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic run_single(input string tag);
        ready = 1'b0;
        ro_free = 1'b1;
        do_start(16'h0001, 16'd100);
        chk({tag, "_s"}, {28'd0, s}, 32'd0);
        chk({tag, "_en_ro"}, {31'd0, en_ro}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_valid(200);
        chk({tag, "_ch"}, {28'd0, data_ch}, 32'd0);
        chk({tag, "_cnt_25pm1"}, {31'd0, (data_cnt >= 16'd24 && data_cnt <= 16'd26)}, 32'd1);
        chk({tag, "_ovf"}, {31'd0, data_ovf}, 32'd0);
        chk({tag, "_hold_en_ro"}, {31'd0, en_ro}, 32'd0);
        ready = 1'b1;
        tick();
        chk({tag, "_vld_drop"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_s_ret"}, {28'd0, s}, 32'd0);
        tick();
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        ready = 1'b0;
        ro_free = 1'b0;
    endtask

    logic [3:0]  cap_ch;
    logic [15:0] cap_cnt;
    logic        cap_ovf;
    int          nvld;
    int          nwait;
    logic        seen_done;
    logic [3:0]  ch_log [3];
    logic [3:0]  s_log [3];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ch_mask = '0;
        win_len = '0;
        ready = 1'b0;
        ro_free = 1'b0;
        ro_req = 0;
        repeat (3) tick();
        chk("rst_outs", {5'd0, s, en_ro, busy, data_valid, data_ch, data_cnt, data_ovf, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_single("single");

        // Scan order with READY held high: exactly three one-cycle results.
        ready = 1'b1;
        do_start(16'h8005, 16'd4);
        nvld = 0;
        seen_done = 1'b0;
        for (int n = 0; n < 300 && !seen_done; n++) begin
            if (data_valid) begin
                if (nvld < 3) begin
                    ch_log[nvld] = data_ch;
                    s_log[nvld] = s;
                end
                nvld++;
            end
            if (done) seen_done = 1'b1;
            else tick();
        end
        chk("scan_done", {31'd0, seen_done}, 32'd1);
        chk("scan_nvalid", nvld, 32'd3);
        chk("scan_ch0", {28'd0, ch_log[0]}, 32'd0);
        chk("scan_ch1", {28'd0, ch_log[1]}, 32'd2);
        chk("scan_ch2", {28'd0, ch_log[2]}, 32'd15);
        chk("scan_s0", {28'd0, s_log[0]}, 32'd0);
        chk("scan_s1", {28'd0, s_log[1]}, 32'd2);
        chk("scan_s2", {28'd0, s_log[2]}, 32'd15);
        chk("scan_s_end", {28'd0, s}, 32'd0);
        ready = 1'b0;
        tick();

        // Backpressure: result and S frozen while READY is low.
        ro_free = 1'b1;
        do_start(16'h0003, 16'd8);
        wait_valid(100);
        cap_ch = data_ch;
        cap_cnt = data_cnt;
        cap_ovf = data_ovf;
        chk("bp_ch", {28'd0, cap_ch}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_vld", {31'd0, data_valid}, 32'd1);
            chk("bp_dat", {11'd0, data_ch, data_cnt, data_ovf}, {11'd0, cap_ch, cap_cnt, cap_ovf});
            chk("bp_en_ro", {31'd0, en_ro}, 32'd0);
            chk("bp_s", {28'd0, s}, 32'd0);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_after_vld", {31'd0, data_valid}, 32'd0);
        chk("bp_after_s", {28'd0, s}, 32'd1);
        chk("bp_after_en_ro", {31'd0, en_ro}, 32'd1);
        wait_valid(100);
        chk("bp_ch1", {28'd0, data_ch}, 32'd1);
        ready = 1'b1;
        wait_done(20);
        ready = 1'b0;
        ro_free = 1'b0;
        tick();

        // Empty mask: FINISH directly, DONE two cycles after START.
        do_start(16'h0000, 16'd10);
        chk("empty_busy", {31'd0, busy}, 32'd1);
        chk("empty_done_early", {31'd0, done}, 32'd0);
        chk("empty_vld0", {31'd0, data_valid}, 32'd0);
        tick();
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_busy_drop", {31'd0, busy}, 32'd0);
        chk("empty_vld1", {31'd0, data_valid}, 32'd0);
        tick();
        chk("empty_done_1cyc", {31'd0, done}, 32'd0);

        // WIN_LEN=0 counts for one cycle: VALID five cycles after START was taken.
        do_start(16'h0001, 16'd0);
        nwait = 0;
        while (!data_valid && nwait < 50) begin
            tick();
            nwait++;
        end
        chk("win0_latency", nwait, 32'd5);
        chk("win0_cnt", {16'd0, data_cnt}, 32'd0);
        ready = 1'b1;
        wait_done(20);
        ready = 1'b0;
        tick();

        // Overflow: exactly 20 edges inside a 100-cycle window.
        do_start(16'h0001, 16'd100);
        repeat (6) tick();
        ro_req = ro_done + 20;
        wait_valid(200);
        chk("ovf16_cnt", {16'd0, data_cnt}, 32'd20);
        chk("ovf16_flag", {31'd0, data_ovf}, 32'd0);
        chk("ovf4_vld", {31'd0, data_valid4}, 32'd1);
`ifdef RO_CNT_SAT_EN
        chk("ovf4_cnt", {28'd0, data_cnt4}, 32'd15);
`else
        chk("ovf4_cnt", {28'd0, data_cnt4}, 32'd4);
`endif
        chk("ovf4_flag", {31'd0, data_ovf4}, 32'd1);
        ready = 1'b1;
        wait_done(20);
        ready = 1'b0;
        tick();

        // Reset mid-COUNT, then a fresh scan.
        ro_free = 1'b1;
        do_start(16'h0001, 16'd100);
        repeat (30) tick();
        chk("mid_en_ro", {31'd0, en_ro}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {5'd0, s, en_ro, busy, data_valid, data_ch, data_cnt, data_ovf, done}, 32'd0);
        chk("mid_rst_outs4", {17'd0, s4, en_ro4, busy4, data_valid4, data_ch4, data_cnt4, data_ovf4, done4}, 32'd0);
        ro_free = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_single("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
